// File: rtl/ram_arbiter_pkg.sv
// Shared types and defaults for the RAM arbiter slice.
//  state_e   : controller state (INIT sweep / RUN arbitration)
//  idx_width : bits needed to hold a requester index
package ram_arbiter_pkg;

    localparam int unsigned DEF_NREQ   = 2;
    localparam int unsigned DEF_DWIDTH = 16;
    localparam int unsigned DEF_AWIDTH = 3;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bus of the RAM arbiter.
//  req/req_we/req_addr/req_wdata : per-requester access, packed by index
//  gnt                           : one-hot access ack (combinational)
//  rsp_valid/rsp_data            : registered read response
//  init_done                     : RAM clear sweep finished
// master = requesters, slave = arbiter.
interface ram_arbiter_if #(
    parameter int unsigned NREQ   = ram_arbiter_pkg::DEF_NREQ,
    parameter int unsigned DWIDTH = ram_arbiter_pkg::DEF_DWIDTH,
    parameter int unsigned AWIDTH = ram_arbiter_pkg::DEF_AWIDTH
);
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        req_we;
    logic [NREQ*AWIDTH-1:0] req_addr;
    logic [NREQ*DWIDTH-1:0] req_wdata;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        rsp_valid;
    logic [DWIDTH-1:0]      rsp_data;
    logic                   init_done;

    modport master (
        output req, req_we, req_addr, req_wdata,
        input  gnt, rsp_valid, rsp_data, init_done
    );

    modport slave (
        input  req, req_we, req_addr, req_wdata,
        output gnt, rsp_valid, rsp_data, init_done
    );
endinterface

// File: rtl/ram_arbiter_rr_pick.sv
// Round-robin picker (combinational).
//  i_req     : pending requests
//  i_last    : index of the previous winner
//  o_gnt_c   : one-hot winner, zero if nothing pending
//  o_idx_c   : winner index
//  o_valid_c : a winner exists
module ram_arbiter_rr_pick #(
    parameter int unsigned NREQ = ram_arbiter_pkg::DEF_NREQ,
    parameter int unsigned IDXW = ram_arbiter_pkg::idx_width(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDXW-1:0] i_last,
    output logic [NREQ-1:0] o_gnt_c,
    output logic [IDXW-1:0] o_idx_c,
    output logic            o_valid_c
);

    // Search starts just after the last winner and wraps, so the first hit wins.
    always_comb begin
        int unsigned w_cand;
        logic [IDXW-1:0] w_cand_idx;
        o_gnt_c    = '0;
        o_idx_c    = '0;
        o_valid_c  = 1'b0;
        w_cand     = 0;
        w_cand_idx = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_cand     = (32'(i_last) + k) % NREQ;
            w_cand_idx = IDXW'(w_cand);
            if (!o_valid_c && i_req[w_cand_idx]) begin
                o_valid_c           = 1'b1;
                o_idx_c             = w_cand_idx;
                o_gnt_c             = '0;
                o_gnt_c[w_cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM (sync write, async read).
// Clears every RAM word to INIT_VALUE after reset before granting any access.
//  clk, reset_n   : clock, synchronous active-low reset
//  bus (slave)    : requester bus, see ram_arbiter_if
//  o_ram_we/addr/wdata : RAM write port and address (combinational)
//  i_ram_rdata    : RAM async read data, only ever registered here
module ram_arbiter #(
    parameter int unsigned     NREQ       = ram_arbiter_pkg::DEF_NREQ,
    parameter int unsigned     DWIDTH     = ram_arbiter_pkg::DEF_DWIDTH,
    parameter int unsigned     AWIDTH     = ram_arbiter_pkg::DEF_AWIDTH,
    parameter logic [DWIDTH-1:0] INIT_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    ram_arbiter_if.slave      bus,
    output logic              o_ram_we,
    output logic [AWIDTH-1:0] o_ram_addr,
    output logic [DWIDTH-1:0] o_ram_wdata,
    input  logic [DWIDTH-1:0] i_ram_rdata
);
    import ram_arbiter_pkg::*;

    localparam int unsigned       IDXW      = idx_width(NREQ);
    localparam logic [AWIDTH-1:0] LAST_ADDR = '1;
    localparam logic [IDXW-1:0]   LAST_REQ  = IDXW'(NREQ - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [AWIDTH-1:0] r_init_cnt;
    logic [IDXW-1:0]   r_last;
    logic [NREQ-1:0]   r_rsp_valid;
    logic [DWIDTH-1:0] r_rsp_data;
    logic              r_init_done;

    logic [NREQ-1:0]   w_pick_gnt;
    logic [IDXW-1:0]   w_pick_idx;
    logic              w_pick_valid;

    ram_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_pick (
        .i_req     (bus.req),
        .i_last    (r_last),
        .o_gnt_c   (w_pick_gnt),
        .o_idx_c   (w_pick_idx),
        .o_valid_c (w_pick_valid)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= ST_INIT;
        else          r_state <= w_state_nxt;
    end

    // Next state, grant and RAM mux.
    always_comb begin
        w_state_nxt = r_state;
        bus.gnt     = '0;
        o_ram_we    = 1'b0;
        o_ram_addr  = '0;
        o_ram_wdata = '0;
        unique case (r_state)
            ST_INIT: begin
                o_ram_we    = 1'b1;
                o_ram_addr  = r_init_cnt;
                o_ram_wdata = INIT_VALUE;
                if (r_init_cnt == LAST_ADDR) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_pick_valid) begin
                    bus.gnt     = w_pick_gnt;
                    o_ram_we    = bus.req_we[w_pick_idx];
                    o_ram_addr  = bus.req_addr[32'(w_pick_idx) * AWIDTH +: AWIDTH];
                    o_ram_wdata = bus.req_wdata[32'(w_pick_idx) * DWIDTH +: DWIDTH];
                end
            end
            default: ;
        endcase
    end

    // Sweep counter, round-robin pointer and read response registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_init_cnt  <= '0;
            r_last      <= LAST_REQ;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            if (r_state == ST_INIT) begin
                r_init_cnt <= r_init_cnt + AWIDTH'(1);
                if (r_init_cnt == LAST_ADDR) r_init_done <= 1'b1;
            end else if (w_pick_valid) begin
                r_last <= w_pick_idx;
                if (!bus.req_we[w_pick_idx]) begin
                    r_rsp_valid <= w_pick_gnt;
                    r_rsp_data  <= i_ram_rdata;
                end
            end
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.init_done = r_init_done;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter (NREQ=2, DWIDTH=16, AWIDTH=3) with a RAM behind it.
module tb_ram_arbiter;
    localparam int NREQ   = 2;
    localparam int DWIDTH = 16;
    localparam int AWIDTH = 3;
    localparam int DEPTH  = 8;

    logic clk;
    logic reset_n;
    logic              ram_we;
    logic [AWIDTH-1:0] ram_addr;
    logic [DWIDTH-1:0] ram_wdata;
    logic [DWIDTH-1:0] ram_rdata;

    int total = 0;
    int bad   = 0;

    ram_arbiter_if #(.NREQ(NREQ), .DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_if ();

    ram_arbiter #(
        .NREQ(NREQ), .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .INIT_VALUE(16'h0000)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (u_if),
        .o_ram_we    (ram_we),
        .o_ram_addr  (ram_addr),
        .o_ram_wdata (ram_wdata),
        .i_ram_rdata (ram_rdata)
    );

    // RAM: synchronous write, asynchronous read, no reset.
    logic [DWIDTH-1:0] mem [DEPTH];
    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;
    assign ram_rdata = mem[ram_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: sweep position, rr pointer, memory image, response.
    bit                m_known = 0;
    bit                m_init;
    int                m_cnt;
    int                m_last;
    bit                m_init_done;
    logic [NREQ-1:0]   m_rsp_valid;
    logic [DWIDTH-1:0] m_rsp_data;
    logic [DWIDTH-1:0] m_mem [DEPTH];

    always @(negedge clk) begin
        logic [NREQ-1:0]   e_gnt;
        logic              e_we;
        logic [AWIDTH-1:0] e_addr;
        logic [DWIDTH-1:0] e_wd;
        bit                found;
        int                w;
        int                j;
        e_gnt = '0; e_we = 1'b0; e_addr = '0; e_wd = '0; found = 0; w = 0; j = 0;
        if (m_known) begin
            if (m_init) begin
                e_we   = 1'b1;
                e_addr = AWIDTH'(m_cnt);
                e_wd   = 16'h0000;
            end else begin
                for (int off = 1; off <= NREQ; off++) begin
                    j = (m_last + off) % NREQ;
                    if (!found && u_if.req[j]) begin
                        found = 1;
                        w     = j;
                    end
                end
                if (found) begin
                    e_gnt    = '0;
                    e_gnt[w] = 1'b1;
                    e_we     = u_if.req_we[w];
                    e_addr   = u_if.req_addr[w*AWIDTH +: AWIDTH];
                    e_wd     = u_if.req_wdata[w*DWIDTH +: DWIDTH];
                end
            end
            chk("gnt", 32'(u_if.gnt), 32'(e_gnt));
            chk("ram_we", 32'(ram_we), 32'(e_we));
            chk("ram_addr", 32'(ram_addr), 32'(e_addr));
            if (e_we) chk("ram_wdata", 32'(ram_wdata), 32'(e_wd));
            chk("rsp_valid", 32'(u_if.rsp_valid), 32'(m_rsp_valid));
            chk("rsp_data", 32'(u_if.rsp_data), 32'(m_rsp_data));
            chk("init_done", 32'(u_if.init_done), 32'(m_init_done));
        end
        // Advance the model to what the coming edge must produce.
        if (!reset_n) begin
            m_known     = 1;
            m_init      = 1;
            m_cnt       = 0;
            m_last      = NREQ - 1;
            m_init_done = 0;
            m_rsp_valid = '0;
            m_rsp_data  = '0;
        end else if (m_known) begin
            m_rsp_valid = '0;
            if (m_init) begin
                m_mem[m_cnt] = 16'h0000;
                if (m_cnt == DEPTH - 1) begin
                    m_init      = 0;
                    m_init_done = 1;
                end
                m_cnt = (m_cnt + 1) % DEPTH;
            end else if (found) begin
                m_last = w;
                if (e_we) m_mem[e_addr] = e_wd;
                else begin
                    m_rsp_valid = e_gnt;
                    m_rsp_data  = m_mem[e_addr];
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0] seq3 [4];
        seq3 = '{2'b01, 2'b10, 2'b01, 2'b10};

        reset_n = 1'b0;
        u_if.req = 2'b11; u_if.req_we = 2'b00;
        u_if.req_addr = '0; u_if.req_wdata = '0;
        step(); step();
        @(negedge clk);
        chk("reset init_done", 32'(u_if.init_done), 32'd0);
        chk("reset rsp_valid", 32'(u_if.rsp_valid), 32'd0);
        chk("reset rsp_data", 32'(u_if.rsp_data), 32'd0);
        step();

        // Init sweep with both requests held.
        reset_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk("sweep gnt", 32'(u_if.gnt), 32'd0);
            chk("sweep we", 32'(ram_we), 32'd1);
            chk("sweep addr", 32'(ram_addr), 32'(i));
            chk("sweep data", 32'(ram_wdata), 32'd0);
            chk("sweep init_done", 32'(u_if.init_done), 32'd0);
            step();
        end
        u_if.req = 2'b00;
        @(negedge clk);
        chk("init_done rise", 32'(u_if.init_done), 32'd1);
        step();

        // Alternating reads, req0 first after reset.
        u_if.req = 2'b11; u_if.req_we = 2'b00;
        u_if.req_addr = {3'd2, 3'd1};
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rr gnt", 32'(u_if.gnt), 32'(seq3[c]));
            if (c > 0) chk("rr rsp_valid", 32'(u_if.rsp_valid), 32'(seq3[c-1]));
            step();
        end
        u_if.req = 2'b00;
        @(negedge clk);
        chk("rr last rsp_valid", 32'(u_if.rsp_valid), 32'b10);
        chk("rr rsp_data", 32'(u_if.rsp_data), 32'h0);
        step();

        // req0 write then read back.
        u_if.req = 2'b01; u_if.req_we = 2'b01;
        u_if.req_addr = {3'd0, 3'd3}; u_if.req_wdata = {16'h0000, 16'hBEEF};
        @(negedge clk); chk("wr gnt", 32'(u_if.gnt), 32'b01); step();
        u_if.req_we = 2'b00;
        @(negedge clk); chk("rd gnt", 32'(u_if.gnt), 32'b01); step();
        u_if.req = 2'b00;
        @(negedge clk);
        chk("rd rsp_valid", 32'(u_if.rsp_valid), 32'b01);
        chk("rd rsp_data", 32'(u_if.rsp_data), 32'hBEEF);
        step();

        // Write by req1 visible to read by req0 in the next cycle.
        u_if.req = 2'b10; u_if.req_we = 2'b10;
        u_if.req_addr = {3'd5, 3'd0}; u_if.req_wdata = {16'h1234, 16'h0000};
        @(negedge clk); chk("ord wr gnt", 32'(u_if.gnt), 32'b10); step();
        u_if.req = 2'b01; u_if.req_we = 2'b00; u_if.req_addr = {3'd0, 3'd5};
        @(negedge clk); chk("ord rd gnt", 32'(u_if.gnt), 32'b01); step();
        u_if.req = 2'b00;
        @(negedge clk);
        chk("ord rsp_valid", 32'(u_if.rsp_valid), 32'b01);
        chk("ord rsp_data", 32'(u_if.rsp_data), 32'h1234);
        step();

        // req0 alone, then req1 joins.
        u_if.req = 2'b01; u_if.req_we = 2'b00; u_if.req_addr = {3'd5, 3'd3};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); chk("solo gnt", 32'(u_if.gnt), 32'b01); step();
        end
        u_if.req = 2'b11;
        @(negedge clk); chk("join gnt1", 32'(u_if.gnt), 32'b10); step();
        @(negedge clk);
        chk("join gnt0", 32'(u_if.gnt), 32'b01);
        chk("join rsp_valid", 32'(u_if.rsp_valid), 32'b10);
        chk("join rsp_data", 32'(u_if.rsp_data), 32'h1234);
        step();
        u_if.req = 2'b00;
        @(negedge clk);
        chk("join rsp_valid0", 32'(u_if.rsp_valid), 32'b01);
        chk("join rsp_data0", 32'(u_if.rsp_data), 32'hBEEF);
        step();

        // Reset while a read is granted, then again mid-sweep.
        u_if.req = 2'b01; reset_n = 1'b0;
        @(negedge clk); chk("rst gnt", 32'(u_if.gnt), 32'b01); step();
        reset_n = 1'b1; u_if.req = 2'b00;
        @(negedge clk);
        chk("rst rsp_valid", 32'(u_if.rsp_valid), 32'd0);
        chk("rst init_done", 32'(u_if.init_done), 32'd0);
        chk("rst addr0", 32'(ram_addr), 32'd0);
        step();
        for (int i = 1; i < 4; i++) begin
            @(negedge clk); chk("part sweep addr", 32'(ram_addr), 32'(i)); step();
        end
        reset_n = 1'b0;
        @(negedge clk); chk("mid addr4", 32'(ram_addr), 32'd4); step();
        reset_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk("resweep addr", 32'(ram_addr), 32'(i));
            chk("resweep init_done", 32'(u_if.init_done), 32'd0);
            step();
        end
        @(negedge clk);
        chk("resweep done", 32'(u_if.init_done), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
